dbg_cmd_arbiter: RTL and testbench

Shares the single core debug-module command port between `N_REQ` debug hosts, for example a UART debug bridge and a JTAG DTM. It uses round-robin arbitration and holds each grant for the complete command/done handshake. A host that halts the core gets an ownership lock until it resumes the core. A watchdog converts a missing `done` into an error response. The block sits between the host-side bridges and the core debug module's `cmd/addr/data/done` bus.

---
 rtl/dbg_cmd_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dbg_cmd_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_arbiter.sv
// Round-robin arbiter sharing the core debug command port between N_REQ hosts,
// with a halt-ownership lock and a watchdog that turns a missing done into an error.
module dbg_cmd_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rstn_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [8*N_REQ-1:0]       req_cmd_i,
    input  logic [32*N_REQ-1:0]      req_addr_i,
    input  logic [32*N_REQ-1:0]      req_wdata_i,
    output logic [31:0]              req_rdata_o,
    output logic [N_REQ-1:0]         req_done_o,
    output logic [N_REQ-1:0]         req_err_o,
    output logic [7:0]               dbg_cmd_o,
    output logic [31:0]              dbg_addr_o,
    output logic [31:0]              dbg_wdata_o,
    input  logic [31:0]              dbg_rdata_i,
    input  logic                     dbg_done_i,
    output logic                     lock_valid_o,
    output logic [$clog2(N_REQ)-1:0] lock_owner_o
);

    localparam int            IW         = $clog2(N_REQ);
    localparam logic [15:0]   CNT_LAST   = 16'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);
    localparam logic [7:0]    CMD_HALT   = 8'h01;
    localparam logic [7:0]    CMD_RESUME = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic            lock_v_q, lock_v_d;
    logic [IW-1:0]   lock_o_q, lock_o_d;

    logic [N_REQ-1:0] elig;
    logic [IW:0]      pick;
    logic [IW-1:0]    pick_idx;

    // First eligible index at or after the pointer; MSB flags a hit.
    function automatic logic [IW:0] rr_pick(
        input logic [N_REQ-1:0] e,
        input logic [IW-1:0]    p
    );
        logic [IW:0]   r;
        logic [IW-1:0] jj;
        int            j;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = IW'(j);
            if (e[jj]) begin
                r = {1'b1, jj};
            end
        end
        return r;
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid_i[i]
                   && (req_cmd_i[8*i +: 8] != 8'h00)
                   && (!lock_v_q || (lock_o_q == IW'(i)));
        end
    end

    always_comb begin
        pick     = rr_pick(elig, ptr_q);
        pick_idx = pick[IW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = '0;
        err_d    = '0;
        lock_v_d = lock_v_q;
        lock_o_d = lock_o_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick[IW]) begin
                    gnt_d   = pick_idx;
                    cmd_d   = req_cmd_i[{pick_idx, 3'b000} +: 8];
                    addr_d  = req_addr_i[{pick_idx, 5'b00000} +: 32];
                    wdata_d = req_wdata_i[{pick_idx, 5'b00000} +: 32];
                    cnt_d   = '0;
                    ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                if (dbg_done_i) begin
                    rdata_d       = dbg_rdata_i;
                    done_d[gnt_q] = 1'b1;
                    if (cmd_q == CMD_HALT) begin
                        lock_v_d = 1'b1;
                        lock_o_d = gnt_q;
                    end else if (cmd_q == CMD_RESUME && lock_v_q
                                 && lock_o_q == gnt_q) begin
                        lock_v_d = 1'b0;
                    end
                    state_d = S_RELEASE;
                    cmd_d   = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d      = '0;
                    err_d[gnt_q] = 1'b1;
                    state_d      = S_RELEASE;
                    cmd_d        = '0;
                    addr_d       = '0;
                    wdata_d      = '0;
                end
            end
            // dbg_done_i may still be high here from the previous command.
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            lock_v_q <= 1'b0;
            lock_o_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            lock_v_q <= lock_v_d;
            lock_o_q <= lock_o_d;
        end
    end

    assign dbg_cmd_o    = cmd_q;
    assign dbg_addr_o   = addr_q;
    assign dbg_wdata_o  = wdata_q;
    assign req_rdata_o  = rdata_q;
    assign req_done_o   = done_q;
    assign req_err_o    = err_q;
    assign lock_valid_o = lock_v_q;
    assign lock_owner_o = lock_o_q;

endmodule

// File: tb/tb_dbg_cmd_arbiter.sv
// Scoreboard bench for dbg_cmd_arbiter: transaction-level host/lock model,
// behavioural debug-module responder, and a monitor that checks every response.
module tb_dbg_cmd_arbiter;

    localparam int N  = 3;
    localparam int T  = 4;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [N-1:0]    req_valid_i;
    logic [8*N-1:0]  req_cmd_i;
    logic [32*N-1:0] req_addr_i;
    logic [32*N-1:0] req_wdata_i;
    logic [31:0]     req_rdata_o;
    logic [N-1:0]    req_done_o;
    logic [N-1:0]    req_err_o;
    logic [7:0]      dbg_cmd_o;
    logic [31:0]     dbg_addr_o;
    logic [31:0]     dbg_wdata_o;
    logic [31:0]     dbg_rdata_i;
    logic            dbg_done_i;
    logic            lock_valid_o;
    logic [IW-1:0]   lock_owner_o;

    always #5 clk = ~clk;

    dbg_cmd_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk          (clk),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_cmd_i    (req_cmd_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rdata_o  (req_rdata_o),
        .req_done_o   (req_done_o),
        .req_err_o    (req_err_o),
        .dbg_cmd_o    (dbg_cmd_o),
        .dbg_addr_o   (dbg_addr_o),
        .dbg_wdata_o  (dbg_wdata_o),
        .dbg_rdata_i  (dbg_rdata_i),
        .dbg_done_i   (dbg_done_i),
        .lock_valid_o (lock_valid_o),
        .lock_owner_o (lock_owner_o)
    );

    typedef struct {
        int          host;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        bit          lv;
        int          lo;
        int          delta;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    bit          hv[N];
    logic [7:0]  hc[N];
    logic [31:0] ha[N];
    logic [31:0] hw[N];

    int  m_ptr;
    bit  m_lv;
    int  m_lo;

    int          dm_lat  = 0;
    int          dm_hold = 0;
    logic [31:0] dm_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]        = hv[i];
            req_cmd_i[8*i +: 8]   = hc[i];
            req_addr_i[32*i +: 32]  = ha[i];
            req_wdata_i[32*i +: 32] = hw[i];
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] c,
                           input logic [31:0] a);
        hv[i] = 1'b1;
        hc[i] = c;
        ha[i] = a;
        hw[i] = $urandom;
    endtask

    // Who should win: first requesting host with a non-zero command at or
    // after the pointer, restricted to the lock owner while locked.
    function automatic int predict();
        int j;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (hv[j] && hc[j] != 8'h00 && (!m_lv || m_lo == j)) begin
                return j;
            end
        end
        return -1;
    endfunction

    // Debug-module responder: done lands at the L-th issue edge, optionally
    // held one extra cycle; lat 0 never answers.
    initial begin
        int n;
        int hold;
        dbg_done_i  = 1'b0;
        dbg_rdata_i = '0;
        n    = 0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                dbg_done_i = 1'b0;
                n    = 0;
                hold = 0;
            end else begin
                if (dbg_done_i) begin
                    if (hold > 0) hold--;
                    else dbg_done_i = 1'b0;
                end
                if (dbg_cmd_o != 8'h00) begin
                    n++;
                    if (n == dm_lat && !dbg_done_i) begin
                        dbg_done_i  = 1'b1;
                        dbg_rdata_i = dm_rdata;
                        hold        = dm_hold;
                    end
                end else begin
                    n = 0;
                end
                if (!dbg_done_i) dbg_rdata_i = $urandom;
            end
        end
    end

    // Monitor: checks issued fields and every response against the queue.
    initial begin
        logic [7:0]   prev_cmd;
        int           issue_cyc;
        exp_t         e;
        logic [N-1:0] oh;
        prev_cmd  = '0;
        issue_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                prev_cmd = '0;
            end else begin
                if (dbg_cmd_o != 8'h00 && prev_cmd == 8'h00) begin
                    issue_cyc = cyc;
                    if (sb.size() == 0) begin
                        chk("spurious_issue", 64'(dbg_cmd_o), 64'd0);
                    end else begin
                        chk("issue_cmd", 64'(dbg_cmd_o), 64'(sb[0].cmd));
                        chk("issue_addr", 64'(dbg_addr_o), 64'(sb[0].addr));
                        chk("issue_wdata", 64'(dbg_wdata_o), 64'(sb[0].wdata));
                    end
                end
                prev_cmd = dbg_cmd_o;
                if ((req_done_o | req_err_o) != '0) begin
                    if (sb.size() == 0) begin
                        chk("spurious_resp", 64'({req_done_o, req_err_o}), 64'd0);
                    end else begin
                        e  = sb.pop_front();
                        oh = '0;
                        oh[e.host] = 1'b1;
                        chk("resp_done", 64'(req_done_o), e.err ? 64'd0 : 64'(oh));
                        chk("resp_err", 64'(req_err_o), e.err ? 64'(oh) : 64'd0);
                        chk("resp_rdata", 64'(req_rdata_o), 64'(e.rdata));
                        chk("release_cmd", 64'(dbg_cmd_o), 64'd0);
                        chk("release_addr", 64'(dbg_addr_o), 64'd0);
                        chk("lock_valid", 64'(lock_valid_o), 64'(e.lv));
                        if (e.lv) chk("lock_owner", 64'(lock_owner_o), 64'(e.lo));
                        chk("latency", 64'(cyc - issue_cyc), 64'(e.delta));
                    end
                end
            end
        end
    end

    // One arbitration round from an IDLE negedge: predict, arm the responder,
    // queue the expectation, wait for the granted host's response.
    task automatic do_round(input int lat, input int hold,
                            input logic [31:0] rd, output int g);
        exp_t e;
        int   k;
        g = predict();
        if (g < 0) begin
            @(negedge clk);
            return;
        end
        if (lat < 0) lat = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, T));
        if (hold < 0) hold = int'($urandom_range(0, 1));
        dm_lat   = lat;
        dm_hold  = hold;
        dm_rdata = rd;
        e.host   = g;
        e.cmd    = hc[g];
        e.addr   = ha[g];
        e.wdata  = hw[g];
        e.err    = (lat == 0);
        e.rdata  = e.err ? 32'h0 : rd;
        e.delta  = e.err ? T : lat;
        m_ptr = (g + 1) % N;
        if (!e.err) begin
            if (hc[g] == 8'h01) begin
                m_lv = 1'b1;
                m_lo = g;
            end else if (hc[g] == 8'h02 && m_lv && m_lo == g) begin
                m_lv = 1'b0;
            end
        end
        e.lv = m_lv;
        e.lo = m_lo;
        sb.push_back(e);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_done_o[g] || req_err_o[g]) break;
        end
        if (k == 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_wait: host %0d got no response, expected one", g);
        end
        hv[g] = 1'b0;
        apply();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int   g;
        exp_t e;
        int   r;
        rstn_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            hv[i] = 1'b0;
            hc[i] = '0;
            ha[i] = '0;
            hw[i] = '0;
        end
        apply();
        m_ptr = 0;
        m_lv  = 1'b0;
        m_lo  = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 64'(dbg_cmd_o), 64'd0);
        chk("rst_addr", 64'(dbg_addr_o), 64'd0);
        chk("rst_wdata", 64'(dbg_wdata_o), 64'd0);
        chk("rst_rdata", 64'(req_rdata_o), 64'd0);
        chk("rst_done_err", 64'({req_done_o, req_err_o}), 64'd0);
        chk("rst_lock", 64'({lock_valid_o, lock_owner_o}), 64'd0);
        rstn_i = 1'b1;
        @(negedge clk);

        // Single read
        set_req(0, 8'h03, 32'd5);
        apply();
        do_round(2, 0, 32'hDEADBEEF, g);

        // Round-robin between hosts 0 and 1
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!hv[i]) set_req(i, 8'h05, {8'(i), 24'($urandom)});
            end
            apply();
            do_round(int'($urandom_range(1, 3)), 0, $urandom, g);
        end
        hv[0] = 1'b0;
        hv[1] = 1'b0;
        apply();
        @(negedge clk);

        // Halt lock by host 1, host 0 locked out
        set_req(1, 8'h01, 32'h0100_0000);
        apply();
        do_round(2, 0, $urandom, g);
        set_req(0, 8'h03, 32'h0000_0033);
        for (int it = 0; it < 3; it++) begin
            set_req(1, 8'h06, {8'h01, 24'($urandom)});
            apply();
            do_round(2, 0, $urandom, g);
        end
        set_req(1, 8'h02, 32'h0100_0002);
        apply();
        do_round(2, 0, $urandom, g);
        apply();
        do_round(2, 0, $urandom, g);

        // Timeout while locked
        set_req(1, 8'h01, 32'h0100_0011);
        apply();
        do_round(1, 0, $urandom, g);
        set_req(1, 8'h05, 32'h0100_0055);
        apply();
        do_round(0, 0, $urandom, g);

        // Stale done held two cycles, then another request
        set_req(1, 8'h02, 32'h0100_0022);
        apply();
        do_round(2, 1, $urandom, g);
        set_req(0, 8'h07, 32'h0000_0077);
        apply();
        do_round(3, 0, $urandom, g);

        // Reset while a command is outstanding under a held lock
        set_req(1, 8'h01, 32'h0100_0101);
        apply();
        do_round(1, 0, $urandom, g);
        set_req(1, 8'h04, 32'h0100_0404);
        apply();
        dm_lat = 0;
        e.host = 1;
        e.cmd  = 8'h04;
        e.addr = ha[1];
        e.wdata = hw[1];
        e.rdata = '0;
        e.err  = 1'b1;
        e.lv   = 1'b1;
        e.lo   = 1;
        e.delta = T;
        sb.push_back(e);
        repeat (2) @(negedge clk);
        chk("pre_rst_cmd", 64'(dbg_cmd_o), 64'h04);
        #2 rstn_i = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_cmd", 64'(dbg_cmd_o), 64'd0);
        chk("mid_rst_lock", 64'(lock_valid_o), 64'd0);
        chk("mid_rst_pulses", 64'({req_done_o, req_err_o}), 64'd0);
        hv[1] = 1'b0;
        apply();
        m_ptr = 0;
        m_lv  = 1'b0;
        m_lo  = 0;
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);
        set_req(0, 8'h03, 32'h0000_0303);
        apply();
        do_round(2, 0, $urandom, g);

        // Randomised traffic
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!hv[i] && $urandom_range(0, 99) < 50) begin
                    r = int'($urandom_range(0, 9));
                    if (r == 0) set_req(i, 8'h00, {8'(i), 24'($urandom)});
                    else if (r == 1) set_req(i, 8'h01, {8'(i), 24'($urandom)});
                    else if (r <= 3) set_req(i, 8'h02, {8'(i), 24'($urandom)});
                    else set_req(i, 8'($urandom_range(3, 255)), {8'(i), 24'($urandom)});
                end else if (hv[i] && hc[i] == 8'h00 && $urandom_range(0, 1) == 1) begin
                    hv[i] = 1'b0;
                end
            end
            apply();
            do_round(-1, -1, $urandom, g);
        end

        for (int i = 0; i < N; i++) hv[i] = 1'b0;
        apply();
        repeat (10) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
